// File: rtl/universal_shift_register_pkg.sv
// Shared types and default sizing for the universal shift register.
package usr_pkg;

    localparam int USR_WIDTH = 8;
    localparam int USR_CNT_W = 4;

    typedef enum logic [1:0] {
        LOGICAL = 2'b00,
        ROTATE  = 2'b01,
        ARITH   = 2'b10
    } mode_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle between a driver and the universal shift register.
interface usr_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [WIDTH-1:0] d;
    logic             l;
    logic             sh;
    logic             shl;
    logic             si;
    logic [1:0]       mode;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             so;
    logic             busy;
    logic             done;

    modport master (
        output d, l, sh, shl, si, mode, start, count,
        input  q, so, busy, done
    );

    modport slave (
        input  d, l, sh, shl, si, mode, start, count,
        output q, so, busy, done
    );
endinterface

// File: rtl/universal_shift_register_shift_step.sv
// Combinational single-step shifter; mode 2'b11 falls through to logical fill.
module shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_shl,
    input  logic [1:0]       i_mode,
    input  logic             i_si,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_out_bit
);

    logic w_fill;

    // Select fill bit and form the shifted word for the requested direction
    always_comb begin
        w_fill    = 1'b0;
        o_q_next  = i_q;
        o_out_bit = 1'b0;
        if (i_shl) begin
            o_out_bit = i_q[WIDTH-1];
            case (i_mode)
                ROTATE:  w_fill = i_q[WIDTH-1];
                ARITH:   w_fill = 1'b0;
                default: w_fill = i_si;
            endcase
            o_q_next = {i_q[WIDTH-2:0], w_fill};
        end else begin
            o_out_bit = i_q[0];
            case (i_mode)
                ROTATE:  w_fill = i_q[0];
                ARITH:   w_fill = i_q[WIDTH-1];
                default: w_fill = i_si;
            endcase
            o_q_next = {w_fill, i_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit load/shift register with single-step shifts and a counted burst engine.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_WIDTH,
    parameter int CNT_W = USR_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    usr_if.slave bus
);

    state_e           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_so;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_rem;
    logic             r_shl;
    logic [1:0]       r_mode;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_so_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_shl_nxt;
    logic [1:0]       w_mode_nxt;

    logic             w_step_shl;
    logic [1:0]       w_step_mode;
    logic [WIDTH-1:0] w_step_q;
    logic             w_step_out;

    // A burst uses the direction/mode latched at start; single steps use live inputs
    always_comb begin
        if (r_state == BURST) begin
            w_step_shl  = r_shl;
            w_step_mode = r_mode;
        end else begin
            w_step_shl  = bus.shl;
            w_step_mode = bus.mode;
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_q       (r_q),
        .i_shl     (w_step_shl),
        .i_mode    (w_step_mode),
        .i_si      (bus.si),
        .o_q_next  (w_step_q),
        .o_out_bit (w_step_out)
    );

    // Next-state and next-output logic; done is a pulse so it defaults low
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_so_nxt    = r_so;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_rem_nxt   = r_rem;
        w_shl_nxt   = r_shl;
        w_mode_nxt  = r_mode;
        case (r_state)
            IDLE: begin
                if (bus.l) begin
                    w_q_nxt = bus.d;
                end else if (bus.start) begin
                    if (bus.count == {CNT_W{1'b0}}) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_rem_nxt   = bus.count;
                        w_shl_nxt   = bus.shl;
                        w_mode_nxt  = bus.mode;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = BURST;
                    end
                end else if (bus.sh) begin
                    w_q_nxt  = w_step_q;
                    w_so_nxt = w_step_out;
                end else begin
                    w_q_nxt = r_q;
                end
            end
            BURST: begin
                w_q_nxt   = w_step_q;
                w_so_nxt  = w_step_out;
                w_rem_nxt = r_rem - {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_rem == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_busy_nxt  = 1'b0;
                w_rem_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers; reset aborts any burst without a done pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_q     <= {WIDTH{1'b0}};
            r_so    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= {CNT_W{1'b0}};
            r_shl   <= 1'b0;
            r_mode  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_so    <= w_so_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_rem   <= w_rem_nxt;
            r_shl   <= w_shl_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.so   = r_so;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
